// File: rtl/decoder_scan.sv
// Scanning N-to-2**N decoder: direct load of a select value, or auto-scan
// through all positions holding each one for DWELL cycles.
module decoder_scan #(
    parameter int N     = 4,
    parameter int DWELL = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            en,
    input  logic            mode,
    input  logic            d_valid,
    input  logic [N-1:0]    d,
    output logic [2**N-1:0] out,
    output logic [N-1:0]    idx,
    output logic            out_valid,
    output logic            wrap
);
    localparam int          W    = 2**N;
    localparam logic [15:0] LAST = 16'(DWELL - 1);

    typedef enum logic [1:0] {IDLE, HOLD, SCAN} state_t;

    state_t      state;
    logic [15:0] cnt;
    logic [N-1:0] idx_inc;

    assign idx_inc = idx + N'(1);

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            idx       <= '0;
            out       <= '0;
            out_valid <= 1'b0;
            wrap      <= 1'b0;
        end else if (!en) begin
            // Blank the output; idx, state and dwell count stay frozen.
            out       <= '0;
            out_valid <= 1'b0;
            wrap      <= 1'b0;
        end else begin
            wrap      <= 1'b0;
            out_valid <= 1'b1;
            out       <= W'(1) << idx;
            if (mode) begin
                if (state == SCAN) begin
                    if (cnt == LAST) begin
                        cnt  <= '0;
                        idx  <= idx_inc;
                        out  <= W'(1) << idx_inc;
                        wrap <= &idx;
                    end else begin
                        cnt <= cnt + 16'd1;
                    end
                end else begin
                    state <= SCAN;
                    cnt   <= '0;
                end
            end else if (state == SCAN) begin
                state <= HOLD;
                cnt   <= '0;
            end else if (d_valid) begin
                state <= HOLD;
                idx   <= d;
                out   <= W'(1) << d;
            end else if (state == IDLE) begin
                // Nothing loaded yet: IDLE stays blank.
                out       <= '0;
                out_valid <= 1'b0;
            end
        end
    end
endmodule
